// File: rtl/pll_loop_filter.sv
// PI loop filter: once per synchronized clk_ref rise, turns err = target - count into a DCO code.
// Drives code_valid for one cycle per applied update and flags lock after LOCK_CNT in-tolerance updates in a row.
module pll_loop_filter #(
  parameter int CODE_W     = 10,
  parameter int CODE_INIT  = 512,
  parameter int ACC_W      = 16,
  parameter int KP_SHIFT   = 2,
  parameter int KI_SHIFT   = 2,
  parameter int SETTLE_CYC = 4,
  parameter int DISCARD    = 2,
  parameter int LOCK_TOL   = 1,
  parameter int LOCK_CNT   = 4
) (
  input  logic              clk_out,
  input  logic              n_rst,
  input  logic              enable,
  input  logic              clk_ref,
  input  logic [7:0]        count,
  input  logic [7:0]        target,
  output logic [CODE_W-1:0] dco_code,
  output logic              code_valid,
  output logic              lock
);

  localparam int TW  = $clog2(SETTLE_CYC + 1);
  localparam int DW  = (DISCARD > 0) ? $clog2(DISCARD + 1) : 1;
  localparam int LCW = $clog2(LOCK_CNT + 1);
  localparam int RW  = ACC_W + 2;

  localparam logic [TW-1:0]         TIMER_LOAD = TW'(SETTLE_CYC);
  localparam logic [DW-1:0]         DISC_LOAD  = DW'(DISCARD);
  localparam logic [LCW-1:0]        LOCK_MAX   = LCW'(LOCK_CNT);
  localparam logic [8:0]            TOL        = 9'(LOCK_TOL);
  localparam logic signed [RW-1:0]  INIT_EXT   = RW'(CODE_INIT);
  localparam logic signed [RW-1:0]  CODE_MAX   = RW'((1 << CODE_W) - 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SETTLE, CALC, UPDATE} state_t;

  state_t                   state_q, state_d;
  logic                     ref_s1_q, ref_s1_d, ref_s2_q, ref_s2_d, ref_s3_q, ref_s3_d;
  logic [TW-1:0]            timer_q, timer_d;
  logic [DW-1:0]            disc_q, disc_d;
  logic signed [8:0]        err_q, err_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CODE_W-1:0]        code_q, code_d;
  logic                     code_valid_q, code_valid_d;
  logic                     lock_q, lock_d;
  logic [LCW-1:0]           lock_cnt_q, lock_cnt_d;

  logic                     rise;
  logic signed [ACC_W:0]    acc_sum;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [RW-1:0]     err_ext, acc_ext, raw;
  logic [CODE_W-1:0]        code_next;
  logic [8:0]               err_abs;
  logic                     in_tol;
  logic [LCW-1:0]           lock_cnt_next;

  assign rise = ref_s2_q & ~ref_s3_q;

  // Datapath for the UPDATE state, evaluated from the registered error.
  always_comb begin
    acc_sum = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-8){err_q[8]}}, err_q};
    if (acc_sum[ACC_W] != acc_sum[ACC_W-1]) begin
      acc_next = acc_sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_next = acc_sum[ACC_W-1:0];
    end
    err_ext = {{(RW-9){err_q[8]}}, err_q};
    acc_ext = {{2{acc_next[ACC_W-1]}}, acc_next};
    raw     = INIT_EXT + (err_ext <<< KP_SHIFT) + (acc_ext >>> KI_SHIFT);
    if (raw[RW-1]) begin
      code_next = '0;
    end else if (raw > CODE_MAX) begin
      code_next = '1;
    end else begin
      code_next = raw[CODE_W-1:0];
    end
    err_abs = err_q[8] ? 9'(-err_q) : err_q;
    in_tol  = (err_abs <= TOL);
    if (!in_tol) begin
      lock_cnt_next = '0;
    end else if (lock_cnt_q == LOCK_MAX) begin
      lock_cnt_next = lock_cnt_q;
    end else begin
      lock_cnt_next = lock_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    ref_s1_d     = clk_ref;
    ref_s2_d     = ref_s1_q;
    ref_s3_d     = ref_s2_q;
    timer_d      = timer_q;
    disc_d       = disc_q;
    err_d        = err_q;
    acc_d        = acc_q;
    code_d       = code_q;
    code_valid_d = 1'b0;
    lock_d       = lock_q;
    lock_cnt_d   = lock_cnt_q;
    if (!enable) begin
      state_d = IDLE;
      disc_d  = DISC_LOAD;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = SETTLE;
            timer_d = TIMER_LOAD;
          end
        end
        SETTLE: begin
          timer_d = timer_q - 1'b1;
          if (timer_q == TW'(1)) state_d = CALC;
        end
        CALC: begin
          err_d   = $signed({1'b0, target}) - $signed({1'b0, count});
          state_d = UPDATE;
        end
        UPDATE: begin
          state_d = IDLE;
          if (disc_q != '0) begin
            disc_d = disc_q - 1'b1;
          end else begin
            acc_d        = acc_next;
            code_d       = code_next;
            lock_cnt_d   = lock_cnt_next;
            lock_d       = (lock_cnt_next == LOCK_MAX);
            code_valid_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_out or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      ref_s1_q     <= 1'b0;
      ref_s2_q     <= 1'b0;
      ref_s3_q     <= 1'b0;
      timer_q      <= '0;
      disc_q       <= DISC_LOAD;
      err_q        <= '0;
      acc_q        <= '0;
      code_q       <= CODE_W'(CODE_INIT);
      code_valid_q <= 1'b0;
      lock_q       <= 1'b0;
      lock_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      ref_s1_q     <= ref_s1_d;
      ref_s2_q     <= ref_s2_d;
      ref_s3_q     <= ref_s3_d;
      timer_q      <= timer_d;
      disc_q       <= disc_d;
      err_q        <= err_d;
      acc_q        <= acc_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      lock_q       <= lock_d;
      lock_cnt_q   <= lock_cnt_d;
    end
  end

  assign dco_code   = code_q;
  assign code_valid = code_valid_q;
  assign lock       = lock_q;

endmodule
